pe_accu_seq: RTL and testbench
==============================

// Module: pe_accu_seq
// PURPOSE
// Sequencer in front of the PE accumulator: takes a job (conv mode, precision, K beats per output group, group count),
// pulls 128-bit partial-product beats from the MAC array by valid/ready and drives the accumulator's data/valid/ctrl pins.
// Control leads data by CTRL_LEAD cycles; spacing between group ends is enforced so the accumulator's output windows never overlap.
// PARAMETERS
// CTRL_LEAD  2   cycles mac_ctrl_*_ori lead the matching accu_in_valid (accumulator ctrl pipe 4 minus data pipe 2)
// CNT_W      16  width of K and group counters
// READ_GAP   3   cycles from last-beat accu_in_valid to mac_ctrl_read in fc mode
// PORTS
// clk              in   1    clock
// rst              in   1    synchronous reset, active-high
// cfg_start        in   1    pulse: latch cfg_*, begin job (ignored while busy)
// cfg_conv_mode    in   2    00 fc, 01 conv, 10 DW, 11 RGB
// cfg_preci        in   2    00 8x4, 01 8x8, 10 16x8, 11 16x16
// cfg_is_fp        in   1    fp select, forwarded
// cfg_k_len        in   CNT_W beats per output group (0 treated as 1)
// cfg_grp_num      in   CNT_W output groups (conv/RGB: total beats)
// busy             out  1    job in progress
// done             out  1    one-cycle pulse at job end
// src_valid        in   1    MAC beat valid
// src_data         in   128  MAC beat (8 taps x 16b)
// src_ready        out  1    beat accepted when src_valid&&src_ready
// accu_in_data     out  128  to accumulator
// accu_in_valid    out  1    to accumulator
// mac_cfg_conv_mode/mac_cfg_preci/mac_cfg_is_fp  out 2/2/1  latched cfg, stable for whole job
// mac_cfg_is_sparse out 1    tied 0
// mac_ctrl_first_ori/mac_ctrl_accu_ori/mac_ctrl_last_ori  out 1 each
// mac_ctrl_read    out  1    fc readout strobe
// BEHAVIOUR
// - Reset: all outputs 0, FSM IDLE, counters 0, data pipe flushed; reset mid-job aborts with no done pulse.
// - FSM IDLE -> (cfg_start) RUN -> (last beat of last group accepted) FLUSH -> (flush counter 0) DONE -> IDLE.
//   cfg_grp_num==0: IDLE -> DONE directly (done one cycle after start). busy=1 in RUN/FLUSH/DONE; done=1 in DONE only.
// - RUN: src_ready=1 unless gap counter !=0. Accepted beat at cycle A: ctrl pins pulse at A+1 (registered),
//   src_data reaches accu_in_data/accu_in_valid at A+1+CTRL_LEAD via CTRL_LEAD-deep register pipe.
// - DW/fc: beat k of group (k=0..K-1): first_ori=(k==0), accu_ori=(k!=0), last_ori=(k==K-1); K=1 -> first&last together.
//   conv/RGB: first/accu/last held 0, every beat streamed, groups unused.
// - End spacing: after a last beat, gap counter blocks next last-beat acceptance until
//   4 cycles (DW 8x8), 2 cycles (DW 16x8/16x16, fc); implemented by dropping src_ready only when the next beat would be a last.
// - fc: mac_ctrl_read pulses 1 cycle at T+READ_GAP, T = accu_in_valid cycle of that group's last beat; read queue depth 2.
// - FLUSH length = CTRL_LEAD+7 cycles covering accumulator drain (out_valid window).
// - cfg_start while busy ignored; cfg_* sampled only on accepted start. No beat lost or duplicated on src stall.
// - Counters: k_cnt wraps to 0 at K-1 and increments grp_cnt; grp_cnt compare width CNT_W, no overflow possible.
// STRUCTURE
// - Shared package pe_pkg: conv-mode/preci enum constants (MODE_FC..MODE_RGB, PRECI_8X4..PRECI_16X16), seq state typedef.
// - Sub-module pe_accu_seq_dpipe: parametric CTRL_LEAD-stage valid+128b delay line with sync reset.
// - Top: FSM, k/grp counters, gap counter, fc read delay shift register.
// TESTING
// - DW 8x8, K=3, G=2, src always valid -> ctrl first,accu,last x2; no stall; accu_in_valid 3 cycles after each accept; done once.
// - DW 8x8, K=1, G=3 -> src_ready drops so last pulses spaced exactly 4 cycles; accumulator out_valid windows disjoint.
// - fc 8x4, K=4, G=2 -> mac_ctrl_read at last-beat accu_in_valid +3, two read pulses total, done after flush.
// - conv, G=5, src_valid toggling 1010.. -> 5 accu_in_valid beats, data order preserved, first/accu/last stay 0.
// - cfg_grp_num=0 -> done pulse one cycle after cfg_start, no accu_in_valid; cfg_start during busy ignored.
// - rst asserted mid-RUN (K=8, after 3 beats) -> next cycle all outputs 0, IDLE, pipe empty, no done.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared PE definitions: conv-mode/precision encodings, sequencer state and
// the group-end spacing rule that keeps accumulator output windows apart.
package pe_pkg;

    localparam int DATA_W = 128;

    typedef enum logic [1:0] {
        MODE_FC   = 2'b00,
        MODE_CONV = 2'b01,
        MODE_DW   = 2'b10,
        MODE_RGB  = 2'b11
    } conv_mode_e;

    typedef enum logic [1:0] {
        PRECI_8X4   = 2'b00,
        PRECI_8X8   = 2'b01,
        PRECI_16X8  = 2'b10,
        PRECI_16X16 = 2'b11
    } preci_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_FLUSH = 2'b10,
        S_DONE  = 2'b11
    } seq_state_e;

    // Minimum cycles between two group-end beats; 8-bit DW drains slowest.
    function automatic logic [2:0] end_gap(conv_mode_e m, preci_e p);
        case (m)
            MODE_DW: return (p == PRECI_8X4 || p == PRECI_8X8) ? 3'd4 : 3'd2;
            MODE_FC: return 3'd2;
            default: return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/pe_accu_seq_dpipe.sv
// Fixed-depth valid+data delay line; lets accumulator data trail its
// control pins by the accumulator's ctrl-vs-data pipe difference.
module pe_accu_seq_dpipe #(
    parameter int STAGES = 2,
    parameter int W      = 128
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    logic [STAGES:1]         vld_pipe;
    logic [STAGES:1][W-1:0]  dat_pipe;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            dat_pipe <= '0;
        end else begin
            vld_pipe[1] <= in_valid;
            dat_pipe[1] <= in_data;
            for (int i = 2; i <= STAGES; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                dat_pipe[i] <= dat_pipe[i-1];
            end
        end
    end

    assign out_valid = vld_pipe[STAGES];
    assign out_data  = dat_pipe[STAGES];

endmodule

// File: rtl/pe_accu_seq.sv
// Accumulator sequencer: pulls MAC beats, emits first/accu/last ctrl one cycle
// after acceptance and the beat itself CTRL_LEAD cycles later, plus fc readout.
module pe_accu_seq
    import pe_pkg::*;
#(
    parameter int CTRL_LEAD = 2,
    parameter int CNT_W     = 16,
    parameter int READ_GAP  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_start,
    input  logic [1:0]        cfg_conv_mode,
    input  logic [1:0]        cfg_preci,
    input  logic              cfg_is_fp,
    input  logic [CNT_W-1:0]  cfg_k_len,
    input  logic [CNT_W-1:0]  cfg_grp_num,
    output logic              busy,
    output logic              done,
    input  logic              src_valid,
    input  logic [DATA_W-1:0] src_data,
    output logic              src_ready,
    output logic [DATA_W-1:0] accu_in_data,
    output logic              accu_in_valid,
    output logic [1:0]        mac_cfg_conv_mode,
    output logic [1:0]        mac_cfg_preci,
    output logic              mac_cfg_is_fp,
    output logic              mac_cfg_is_sparse,
    output logic              mac_ctrl_first_ori,
    output logic              mac_ctrl_accu_ori,
    output logic              mac_ctrl_last_ori,
    output logic              mac_ctrl_read
);

    localparam int FLUSH_LEN = CTRL_LEAD + 7;
    localparam int FL_W      = $clog2(FLUSH_LEN + 1);
    localparam int RD_LEN    = CTRL_LEAD + READ_GAP + 1;

    seq_state_e         state, state_nxt;
    conv_mode_e         mode_q;
    preci_e             preci_q;
    logic               is_fp_q;
    logic [CNT_W-1:0]   k_m1_q, grp_m1_q, k_cnt, grp_cnt;
    logic [2:0]         gap_cnt;
    logic [FL_W-1:0]    fl_cnt;
    logic [RD_LEN-1:0]  rd_sr;
    logic               s0_vld;
    logic [DATA_W-1:0]  s0_data;
    logic               grouped, grp_end, job_last, accept;

    // conv/RGB ignore grouping: grp_cnt then counts raw beats
    assign grouped  = (mode_q == MODE_FC) || (mode_q == MODE_DW);
    assign grp_end  = grouped && (k_cnt == k_m1_q);
    assign job_last = (grp_cnt == grp_m1_q) && (grp_end || !grouped);
    assign src_ready = (state == S_RUN) && !(grp_end && gap_cnt != 3'd0);
    assign accept    = src_valid && src_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (cfg_start) state_nxt = (cfg_grp_num == '0) ? S_DONE : S_RUN;
            S_RUN:   if (accept && job_last) state_nxt = S_FLUSH;
            S_FLUSH: if (fl_cnt == '0) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            mode_q   <= MODE_FC;
            preci_q  <= PRECI_8X4;
            is_fp_q  <= 1'b0;
            k_m1_q   <= '0;
            grp_m1_q <= '0;
            k_cnt    <= '0;
            grp_cnt  <= '0;
            gap_cnt  <= '0;
            fl_cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && cfg_start) begin
                mode_q   <= conv_mode_e'(cfg_conv_mode);
                preci_q  <= preci_e'(cfg_preci);
                is_fp_q  <= cfg_is_fp;
                k_m1_q   <= (cfg_k_len == '0) ? '0 : cfg_k_len - CNT_W'(1);
                grp_m1_q <= cfg_grp_num - CNT_W'(1);
                k_cnt    <= '0;
                grp_cnt  <= '0;
            end else if (accept) begin
                if (!grouped || grp_end) begin
                    k_cnt   <= '0;
                    grp_cnt <= grp_cnt + CNT_W'(1);
                end else begin
                    k_cnt <= k_cnt + CNT_W'(1);
                end
            end
            if (accept && grp_end)       gap_cnt <= end_gap(mode_q, preci_q) - 3'd1;
            else if (gap_cnt != 3'd0)    gap_cnt <= gap_cnt - 3'd1;
            if (accept && job_last)      fl_cnt <= FL_W'(FLUSH_LEN - 1);
            else if (state == S_FLUSH && fl_cnt != '0) fl_cnt <= fl_cnt - FL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mac_ctrl_first_ori <= 1'b0;
            mac_ctrl_accu_ori  <= 1'b0;
            mac_ctrl_last_ori  <= 1'b0;
            s0_vld             <= 1'b0;
            s0_data            <= '0;
            rd_sr              <= '0;
        end else begin
            mac_ctrl_first_ori <= accept && grouped && (k_cnt == '0);
            mac_ctrl_accu_ori  <= accept && grouped && (k_cnt != '0);
            mac_ctrl_last_ori  <= accept && grp_end;
            s0_vld             <= accept;
            if (accept) s0_data <= src_data;
            rd_sr <= {rd_sr[RD_LEN-2:0], accept && grp_end && (mode_q == MODE_FC)};
        end
    end

    pe_accu_seq_dpipe #(.STAGES(CTRL_LEAD), .W(DATA_W)) u_dpipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s0_vld),
        .in_data   (s0_data),
        .out_valid (accu_in_valid),
        .out_data  (accu_in_data)
    );

    assign busy              = (state != S_IDLE);
    assign done              = (state == S_DONE);
    assign mac_ctrl_read     = rd_sr[RD_LEN-1];
    assign mac_cfg_conv_mode = mode_q;
    assign mac_cfg_preci     = preci_q;
    assign mac_cfg_is_fp     = is_fp_q;
    assign mac_cfg_is_sparse = 1'b0;

endmodule

// File: tb/tb_pe_accu_seq.sv
// Bench for pe_accu_seq: each job's expected pin activity is predicted from
// the beat-level rules (acceptance times, group ends, fixed latencies).
module tb_pe_accu_seq;
    import pe_pkg::*;

    localparam int LEAD = 2;
    localparam int RGAP = 3;
    localparam int FLEN = LEAD + 7;
    localparam int MAXC = 200;

    logic         clk = 1'b0;
    logic         rst;
    logic         cfg_start, cfg_is_fp;
    logic [1:0]   cfg_conv_mode, cfg_preci;
    logic [15:0]  cfg_k_len, cfg_grp_num;
    logic         busy, done, src_valid, src_ready, accu_in_valid;
    logic [127:0] src_data, accu_in_data;
    logic [1:0]   mac_cfg_conv_mode, mac_cfg_preci;
    logic         mac_cfg_is_fp, mac_cfg_is_sparse;
    logic         mac_ctrl_first_ori, mac_ctrl_accu_ori, mac_ctrl_last_ori, mac_ctrl_read;

    int total = 0;
    int bad   = 0;
    logic [127:0] beats[$];

    always #5 clk = ~clk;

    pe_accu_seq #(.CTRL_LEAD(LEAD), .CNT_W(16), .READ_GAP(RGAP)) dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_conv_mode(cfg_conv_mode),
        .cfg_preci(cfg_preci), .cfg_is_fp(cfg_is_fp), .cfg_k_len(cfg_k_len),
        .cfg_grp_num(cfg_grp_num), .busy(busy), .done(done), .src_valid(src_valid),
        .src_data(src_data), .src_ready(src_ready), .accu_in_data(accu_in_data),
        .accu_in_valid(accu_in_valid), .mac_cfg_conv_mode(mac_cfg_conv_mode),
        .mac_cfg_preci(mac_cfg_preci), .mac_cfg_is_fp(mac_cfg_is_fp),
        .mac_cfg_is_sparse(mac_cfg_is_sparse), .mac_ctrl_first_ori(mac_ctrl_first_ori),
        .mac_ctrl_accu_ori(mac_ctrl_accu_ori), .mac_ctrl_last_ori(mac_ctrl_last_ori),
        .mac_ctrl_read(mac_ctrl_read)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".busy"},  128'(busy), 128'(0));
        chk({tag, ".done"},  128'(done), 128'(0));
        chk({tag, ".rdy"},   128'(src_ready), 128'(0));
        chk({tag, ".vld"},   128'(accu_in_valid), 128'(0));
        chk({tag, ".data"},  accu_in_data, 128'(0));
        chk({tag, ".ctrl"},  128'({mac_ctrl_first_ori, mac_ctrl_accu_ori, mac_ctrl_last_ori, mac_ctrl_read}), 128'(0));
        chk({tag, ".cfg"},   128'({mac_cfg_conv_mode, mac_cfg_preci, mac_cfg_is_fp, mac_cfg_is_sparse}), 128'(0));
    endtask

    // Predict the job from its rules, then drive it and compare every cycle.
    task automatic run_job(input logic [1:0] mode, input logic [1:0] preci, input int k,
                           input int g, input int pat, input int intr, input string tag);
        int kk, n, sp, j, jd, fin, dc, last_end, b;
        bit grp, fp, isend, e_first, e_accu, e_last, e_vld, e_read;
        bit vpat[MAXC];
        bit acc[MAXC];
        bit rdy[MAXC];
        int bidx[MAXC];
        logic [127:0] ed;

        kk  = (k == 0) ? 1 : k;
        grp = (mode == 2'b00) || (mode == 2'b10);
        n   = (g == 0) ? 0 : (grp ? g * kk : g);
        sp  = !grp ? 0 : ((mode == 2'b10 && preci <= 2'b01) ? 4 : 2);
        fp  = 1'($urandom);
        beats.delete();
        for (int i = 0; i < n; i++) beats.push_back({$urandom, $urandom, $urandom, $urandom});
        for (int c = 0; c < MAXC; c++) begin
            vpat[c] = (pat == 0) ? 1'b1 : (pat == 1) ? (c % 2 == 0) : 1'($urandom);
            acc[c] = 0; rdy[c] = 0; bidx[c] = 0;
        end
        j = 0; last_end = -1000; fin = -1;
        for (int c = 0; c < MAXC; c++) begin
            if (j < n) begin
                isend = grp && (j % kk == kk - 1);
                rdy[c] = !(isend && c < last_end + sp);
                if (rdy[c] && vpat[c]) begin
                    acc[c] = 1; bidx[c] = j;
                    if (isend) last_end = c;
                    if (j == n - 1) fin = c;
                    j++;
                end
            end
        end
        dc = (n == 0) ? 0 : fin + 1 + FLEN;

        @(negedge clk);
        cfg_conv_mode = mode; cfg_preci = preci; cfg_is_fp = fp;
        cfg_k_len = 16'(k); cfg_grp_num = 16'(g); cfg_start = 1'b1;
        jd = 0;
        for (int c = 0; c <= dc + 3; c++) begin
            @(negedge clk);
            cfg_start = (c == intr);
            if (c == 0) begin
                cfg_conv_mode = ~mode; cfg_preci = ~preci; cfg_is_fp = ~fp;
                cfg_k_len = 16'd7; cfg_grp_num = 16'd1;
            end
            src_valid = vpat[c] && (jd < n);
            src_data  = (jd < n) ? beats[jd] : {4{$urandom}};
            #1;
            e_first = 0; e_accu = 0; e_last = 0; e_vld = 0; e_read = 0; ed = '0;
            if (c >= 1 && acc[c-1]) begin
                b = bidx[c-1];
                e_first = grp && (b % kk == 0);
                e_accu  = grp && (b % kk != 0);
                e_last  = grp && (b % kk == kk - 1);
            end
            if (c >= 1 + LEAD && acc[c-1-LEAD]) begin
                e_vld = 1; ed = beats[bidx[c-1-LEAD]];
            end
            if (mode == 2'b00 && c >= 1 + LEAD + RGAP && acc[c-1-LEAD-RGAP])
                e_read = (bidx[c-1-LEAD-RGAP] % kk == kk - 1);
            chk($sformatf("%s.rdy@%0d", tag, c),   128'(src_ready), 128'(rdy[c]));
            chk($sformatf("%s.first@%0d", tag, c), 128'(mac_ctrl_first_ori), 128'(e_first));
            chk($sformatf("%s.accu@%0d", tag, c),  128'(mac_ctrl_accu_ori), 128'(e_accu));
            chk($sformatf("%s.last@%0d", tag, c),  128'(mac_ctrl_last_ori), 128'(e_last));
            chk($sformatf("%s.vld@%0d", tag, c),   128'(accu_in_valid), 128'(e_vld));
            chk($sformatf("%s.read@%0d", tag, c),  128'(mac_ctrl_read), 128'(e_read));
            chk($sformatf("%s.done@%0d", tag, c),  128'(done), 128'(c == dc));
            chk($sformatf("%s.busy@%0d", tag, c),  128'(busy), 128'(c <= dc));
            chk($sformatf("%s.cfg@%0d", tag, c),
                128'({mac_cfg_conv_mode, mac_cfg_preci, mac_cfg_is_fp, mac_cfg_is_sparse}),
                128'({mode, preci, fp, 1'b0}));
            if (e_vld) chk($sformatf("%s.data@%0d", tag, c), accu_in_data, ed);
            if (src_valid && src_ready) jd++;
        end
        src_valid = 1'b0;
        cfg_start = 1'b0;
    endtask

    initial begin
        int nacc;
        rst = 1'b1; cfg_start = 1'b0; cfg_conv_mode = '0; cfg_preci = '0; cfg_is_fp = 1'b0;
        cfg_k_len = '0; cfg_grp_num = '0; src_valid = 1'b0; src_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;

        run_job(2'b10, 2'b01, 3, 2, 0, -1, "dw88_k3g2");
        run_job(2'b10, 2'b01, 1, 3, 0, -1, "dw88_k1g3");
        run_job(2'b00, 2'b00, 4, 2, 0, -1, "fc84_k4g2");
        run_job(2'b01, 2'b00, 0, 5, 1, 3,  "conv_g5_tog");
        run_job(2'b10, 2'b01, 2, 0, 0, 0,  "grp0");
        run_job(2'b10, 2'b10, 2, 4, 2, 5,  "dw168_rand");
        run_job(2'b00, 2'b11, 0, 3, 2, -1, "fc1616_k0_rand");
        run_job(2'b11, 2'b10, 3, 4, 2, -1, "rgb_rand");

        // abort mid-run after three accepted beats
        @(negedge clk);
        cfg_conv_mode = 2'b10; cfg_preci = 2'b01; cfg_is_fp = 1'b1;
        cfg_k_len = 16'd8; cfg_grp_num = 16'd2; cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0; src_valid = 1'b1; src_data = {4{$urandom}};
        nacc = 0;
        for (int i = 0; i < 20 && nacc < 3; i++) begin
            #1;
            if (src_valid && src_ready) nacc++;
            @(negedge clk);
            src_data = {4{$urandom}};
        end
        chk("abort.accepted", 128'(nacc), 128'(3));
        rst = 1'b1;
        @(negedge clk);
        chk_all_zero("abort");
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk($sformatf("abort.post@%0d", c),
                128'({busy, done, accu_in_valid, mac_ctrl_first_ori, mac_ctrl_accu_ori,
                      mac_ctrl_last_ori, mac_ctrl_read}), 128'(0));
        end
        src_valid = 1'b0;

        run_job(2'b00, 2'b10, 2, 2, 2, -1, "fc168_after_abort");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
